imul2_seq_ctrl: RTL

//  Sequential radix-4 multiplier controller. One radix-4 partial-product

---
 rtl/imul2_seq_ctrl.sv | 70 +++++++
 1 files changed

// File: rtl/imul2_seq_ctrl.sv
// imul2_seq_ctrl: sequential radix-4 unsigned multiplier, one 2-bit digit of B per cycle,
// operands taken on a start handshake and the product held under valid/ready.
module imul2_seq_ctrl #(
    parameter int SIZE = 16,
    parameter int CNTW = $clog2(SIZE/2)+1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iStart,
    input  logic [SIZE-1:0]   iA,
    input  logic [SIZE-1:0]   iB,
    output logic              oBusy,
    output logic              oValid,
    input  logic              iReady,
    output logic [2*SIZE-1:0] oResult
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [CNTW-1:0] LAST = CNTW'(SIZE/2-1);
    state_t              state;
    logic [CNTW-1:0]     count;
    logic [SIZE-1:0]     ra, rb;
    logic [2*SIZE+1:0]   acc, sum;
    logic [SIZE+1:0]     pp;
    always_comb begin
        pp  = rb[1:0] == 2'd0 ? '0 :
              rb[1:0] == 2'd1 ? {2'b00, ra} :
              rb[1:0] == 2'd2 ? {1'b0, ra, 1'b0} :
                                {2'b00, ra} + {1'b0, ra, 1'b0};
        // digit weight enters at the top; shifting right keeps acc aligned to the next digit
        sum = acc + {pp, {SIZE{1'b0}}};
    end
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state   <= IDLE;
            count   <= '0;
            ra      <= '0;
            rb      <= '0;
            acc     <= '0;
            oBusy   <= 1'b0;
            oValid  <= 1'b0;
            oResult <= '0;
        end else begin
            case (state)
                IDLE: if (iStart) begin
                    ra    <= iA;
                    rb    <= iB;
                    acc   <= '0;
                    count <= '0;
                    oBusy <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    acc   <= sum >> 2;
                    rb    <= rb >> 2;
                    count <= count + 1'b1;
                    if (count == LAST) state <= DONE;
                end
                DONE: if (!oValid) begin
                    oValid  <= 1'b1;
                    oResult <= acc[2*SIZE-1:0];
                end else if (iReady) begin
                    oValid <= 1'b0;
                    oBusy  <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
